// File: rtl/round_robin_mux_arbiter_if.sv
// Bus between the round-robin arbiter and the requesters / mux select.
// Handshake: request[i] is a level. Requester i raises it and keeps it high
// for as long as it needs the shared resource. grant[i] high means that
// requester i owns the mux path in that cycle. Dropping request[i] releases
// ownership at the next rising edge. grant never has more than one bit set.
// grantValid mirrors |grant, and grantIndex is the binary form of grant.
interface round_robin_mux_arbiter_if #(
  parameter int INPUTS = 4
);
  logic [INPUTS-1:0] request;
  logic [INPUTS-1:0] grant;
  logic              grantValid;
  logic [2:0]        grantIndex;
  logic              timeoutError;
  logic [1:0]        dbg_state;

  // Arbiter side: samples requests and drives the grant outputs.
  modport master (
    input  request,
    output grant,
    output grantValid,
    output grantIndex,
    output timeoutError,
    output dbg_state
  );

  // Requester side: drives requests and observes the grant outputs.
  modport slave (
    output request,
    input  grant,
    input  grantValid,
    input  grantIndex,
    input  timeoutError,
    input  dbg_state
  );
endinterface

// File: rtl/round_robin_mux_arbiter.sv
// Round-robin arbiter that produces a registered one-hot select for a shared
// mux. Ownership is held while the owner keeps requesting. Every release is
// followed by one grant-free cycle. An optional watchdog revokes a grant
// after TIMEOUT cycles and masks the owner until it drops its request.
module round_robin_mux_arbiter #(
  parameter int INPUTS  = 4,
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  round_robin_mux_arbiter_if.master bus
);

  localparam int          IW      = (INPUTS > 2) ? $clog2(INPUTS) : 1;
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [15:0] WD_LAST = WD_EN ? 16'(TIMEOUT - 1) : 16'd0;

  generate
    if (INPUTS < 2 || INPUTS > 8) begin : g_bad_inputs
      $error("round_robin_mux_arbiter: INPUTS must be in 2..8");
    end
    if (TIMEOUT < 0 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("round_robin_mux_arbiter: TIMEOUT must be in 0..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANTED = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     owner_wrap;
  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic [15:0]       cnt_q, cnt_d;
  logic [INPUTS-1:0] mask_q, mask_d;
  logic [INPUTS-1:0] eligible;
  logic              owner_req;
  logic              wd_fire;

  logic [INPUTS-1:0] grant_q, grant_d;
  logic              grant_valid_q, grant_valid_d;
  logic [2:0]        grant_index_q, grant_index_d;
  logic              timeout_q, timeout_d;

  // Requesters that timed out stay out of arbitration until they let go.
  assign eligible   = bus.request & ~mask_q;
  assign owner_req  = bus.request[owner_q];
  assign owner_wrap = (owner_q == IW'(INPUTS - 1)) ? '0 : owner_q + IW'(1);
  // Fires on the edge that would start cycle TIMEOUT+1 of ownership; a
  // simultaneous request drop wins and is treated as a normal release.
  assign wd_fire    = WD_EN && owner_req && (cnt_q == WD_LAST);

  // Round-robin search: first eligible requester at or above the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < INPUTS; k++) begin
      if (!pick_found && eligible[(int'(ptr_q) + k) % INPUTS]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(ptr_q) + k) % INPUTS);
      end
    end
  end

  // State register plus registered outputs; reset clears the grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic. The GAP cycle is the grant-free cycle itself, so the
  // edge that closes it already arbitrates exactly as IDLE does.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q & bus.request;
    case (state_q)
      S_IDLE, S_GAP: begin
        cnt_d = '0;
        if (pick_found) begin
          state_d = S_GRANTED;
          owner_d = pick_idx;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANTED: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (!owner_req) begin
          state_d = S_GAP;
          ptr_d   = owner_wrap;
        end else if (wd_fire) begin
          state_d         = S_GAP;
          ptr_d           = owner_wrap;
          mask_d[owner_q] = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: values loaded into the output registers on the next edge.
  always_comb begin
    grant_d       = '0;
    grant_valid_d = 1'b0;
    grant_index_d = '0;
    timeout_d     = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (pick_found) begin
          grant_d       = {{(INPUTS-1){1'b0}}, 1'b1} << pick_idx;
          grant_valid_d = 1'b1;
          grant_index_d = 3'(pick_idx);
        end
      end
      S_GRANTED: begin
        if (owner_req && wd_fire) begin
          timeout_d = 1'b1;
        end else if (owner_req) begin
          grant_d       = grant_q;
          grant_valid_d = 1'b1;
          grant_index_d = grant_index_q;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.grant        = grant_q;
  assign bus.grantValid   = grant_valid_q;
  assign bus.grantIndex   = grant_index_q;
  assign bus.timeoutError = timeout_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// Bench for round_robin_mux_arbiter: three instances (TIMEOUT 0, 8, 4) share
// clock and reset; a per-instance ownership model predicts every output.
module tb_round_robin_mux_arbiter;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  round_robin_mux_arbiter_if #(.INPUTS(N)) bus0 ();
  round_robin_mux_arbiter_if #(.INPUTS(N)) bus8 ();
  round_robin_mux_arbiter_if #(.INPUTS(N)) bus4 ();

  round_robin_mux_arbiter #(.INPUTS(N), .TIMEOUT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
  round_robin_mux_arbiter #(.INPUTS(N), .TIMEOUT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.master));
  round_robin_mux_arbiter #(.INPUTS(N), .TIMEOUT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.master));

  logic [N-1:0] g_obs [3];
  logic [2:0]   i_obs [3];
  logic         v_obs [3];
  logic         t_obs [3];
  assign g_obs[0] = bus0.grant;  assign i_obs[0] = bus0.grantIndex;
  assign v_obs[0] = bus0.grantValid; assign t_obs[0] = bus0.timeoutError;
  assign g_obs[1] = bus8.grant;  assign i_obs[1] = bus8.grantIndex;
  assign v_obs[1] = bus8.grantValid; assign t_obs[1] = bus8.timeoutError;
  assign g_obs[2] = bus4.grant;  assign i_obs[2] = bus4.grantIndex;
  assign v_obs[2] = bus4.grantValid; assign t_obs[2] = bus4.timeoutError;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  // Ownership view: who owns the resource, how many cycles it has been held,
  // where the round-robin search starts, and who is locked out after a timeout.
  int           m_to [3] = '{0, 8, 4};
  int           m_owner [3];
  int           m_held [3];
  int           m_ptr [3];
  logic [N-1:0] m_mask [3];
  bit           m_tmo [3];
  logic [N-1:0] req [3];
  logic [N-1:0] exp_q [$];

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_owner[d] = -1;
      m_held[d]  = 0;
      m_ptr[d]   = 0;
      m_mask[d]  = '0;
      m_tmo[d]   = 1'b0;
    end
  endfunction

  function automatic void model_edge(int d, logic [N-1:0] r);
    logic [N-1:0] nm;
    bit           found;
    nm       = m_mask[d] & r;
    m_tmo[d] = 1'b0;
    if (m_owner[d] >= 0) begin
      m_held[d]++;
      if (!r[m_owner[d]]) begin
        m_ptr[d]   = (m_owner[d] + 1) % N;
        m_owner[d] = -1;
      end else if (m_to[d] != 0 && m_held[d] == m_to[d]) begin
        nm[m_owner[d]] = 1'b1;
        m_tmo[d]       = 1'b1;
        m_ptr[d]       = (m_owner[d] + 1) % N;
        m_owner[d]     = -1;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr[d] + k) % N;
        if (!found && r[c] && !m_mask[d][c]) begin
          found      = 1'b1;
          m_owner[d] = c;
          m_held[d]  = 0;
        end
      end
    end
    m_mask[d] = nm;
  endfunction

  function automatic logic [N-1:0] exp_grant(int d);
    logic [N-1:0] g;
    g = '0;
    if (m_owner[d] >= 0) g[m_owner[d]] = 1'b1;
    return g;
  endfunction

  function automatic logic [2:0] exp_index(int d);
    return (m_owner[d] >= 0) ? 3'(m_owner[d]) : 3'd0;
  endfunction

  // ---------------- driver tasks ----------------
  // Drive req[] at the falling edge, let the rising edge happen, step the
  // model, and return 1 time unit after the edge for sampling.
  task automatic tick();
    @(negedge clk);
    bus0.request = req[0];
    bus8.request = req[1];
    bus4.request = req[2];
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int d = 0; d < 3; d++) model_edge(d, req[d]);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    model_reset();
    for (int d = 0; d < 3; d++) req[d] = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req[0] = 4'b1111; req[1] = '0; req[2] = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        tests_run++;
        if (g_obs[d] !== '0 || v_obs[d] !== 1'b0 || i_obs[d] !== 3'd0 || t_obs[d] !== 1'b0) begin
          tests_failed++;
          $display("FAIL reset_hold d=%0d got g=%b v=%b i=%0d t=%b want all zero", d, g_obs[d], v_obs[d], i_obs[d], t_obs[d]);
        end
      end
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (g_obs[0] !== 4'b0001 || v_obs[0] !== 1'b1 || i_obs[0] !== 3'd0 || g_obs[0] !== exp_grant(0)) begin
      tests_failed++;
      $display("FAIL reset_release got g=%b v=%b i=%0d want g=0001 v=1 i=0", g_obs[0], v_obs[0], i_obs[0]);
    end
  endtask

  task automatic test_single();
    int granted;
    reset_all();
    granted = 0;
    for (int c = 0; c < 9; c++) begin
      req[0] = (c < 5) ? 4'b0100 : 4'b0000;
      tick();
      if (g_obs[0] === 4'b0100 && i_obs[0] === 3'd2) granted++;
      tests_run++;
      if (g_obs[0] !== exp_grant(0) || i_obs[0] !== exp_index(0) || v_obs[0] !== (m_owner[0] >= 0) || t_obs[0] !== m_tmo[0]) begin
        tests_failed++;
        $display("FAIL single cyc=%0d got g=%b i=%0d v=%b t=%b want g=%b i=%0d t=%b", c, g_obs[0], i_obs[0], v_obs[0], t_obs[0], exp_grant(0), exp_index(0), m_tmo[0]);
      end
    end
    tests_run++;
    if (granted !== 5) begin
      tests_failed++;
      $display("FAIL single_len got %0d granted cycles want 5", granted);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] prev, want;
    int zeros;
    bit started;
    reset_all();
    exp_q = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    prev = '0; zeros = 0; started = 1'b0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      req[0] = 4'b1011;
      if (m_owner[0] >= 0 && m_held[0] == 2) req[0][m_owner[0]] = 1'b0;
      tick();
      tests_run++;
      if (g_obs[0] !== exp_grant(0) || i_obs[0] !== exp_index(0) || v_obs[0] !== (m_owner[0] >= 0)) begin
        tests_failed++;
        $display("FAIL fair cyc=%0d got g=%b i=%0d v=%b want g=%b i=%0d", c, g_obs[0], i_obs[0], v_obs[0], exp_grant(0), exp_index(0));
      end
      if (g_obs[0] !== '0 && g_obs[0] !== prev) begin
        if (started) begin
          tests_run++;
          if (zeros !== 1) begin
            tests_failed++;
            $display("FAIL fair_gap cyc=%0d got %0d idle cycles want 1", c, zeros);
          end
        end
        want = exp_q.pop_front();
        tests_run++;
        if (g_obs[0] !== want) begin
          tests_failed++;
          $display("FAIL fair_order cyc=%0d got g=%b want g=%b", c, g_obs[0], want);
        end
        started = 1'b1;
      end
      zeros = (g_obs[0] === '0) ? zeros + 1 : 0;
      prev  = g_obs[0];
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL fair_budget got %0d grants outstanding want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_watchdog();
    logic [N-1:0] hist [0:26];
    logic         thist [0:26];
    int run, tmo_cnt, late;
    reset_all();
    for (int c = 1; c <= 26; c++) begin
      req[1] = (c == 25) ? 4'b0010 : 4'b0011;
      tick();
      hist[c]  = g_obs[1];
      thist[c] = t_obs[1];
      tests_run++;
      if (g_obs[1] !== exp_grant(1) || i_obs[1] !== exp_index(1) || t_obs[1] !== m_tmo[1]) begin
        tests_failed++;
        $display("FAIL wdog cyc=%0d got g=%b i=%0d t=%b want g=%b i=%0d t=%b", c, g_obs[1], i_obs[1], t_obs[1], exp_grant(1), exp_index(1), m_tmo[1]);
      end
    end
    run = 0; tmo_cnt = 0; late = 0;
    for (int c = 1; c <= 8; c++) if (hist[c] === 4'b0001) run++;
    for (int c = 1; c <= 17; c++) if (thist[c] === 1'b1) tmo_cnt++;
    for (int c = 19; c <= 24; c++) if (hist[c] !== 4'b0000) late++;
    tests_run++;
    if (run !== 8 || hist[9] !== 4'b0000) begin
      tests_failed++;
      $display("FAIL wdog_len got %0d owner cycles then g=%b want 8 then 0000", run, hist[9]);
    end
    tests_run++;
    if (tmo_cnt !== 1 || thist[9] !== 1'b1) begin
      tests_failed++;
      $display("FAIL wdog_pulse got %0d pulses (cycle9=%b) want 1 at cycle 9", tmo_cnt, thist[9]);
    end
    tests_run++;
    if (hist[10] !== 4'b0010) begin
      tests_failed++;
      $display("FAIL wdog_next got g=%b want 0010", hist[10]);
    end
    tests_run++;
    if (late !== 0) begin
      tests_failed++;
      $display("FAIL wdog_mask got %0d granted cycles while both masked want 0", late);
    end
    tests_run++;
    if (hist[26] !== 4'b0001) begin
      tests_failed++;
      $display("FAIL wdog_regrant got g=%b want 0001", hist[26]);
    end
  endtask

  task automatic test_watchdog_tie();
    int pulses;
    reset_all();
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      req[2] = (c == 5) ? 4'b0000 : 4'b0001;
      tick();
      if (t_obs[2] === 1'b1) pulses++;
      tests_run++;
      if (g_obs[2] !== exp_grant(2) || t_obs[2] !== m_tmo[2]) begin
        tests_failed++;
        $display("FAIL tie cyc=%0d got g=%b t=%b want g=%b t=%b", c, g_obs[2], t_obs[2], exp_grant(2), m_tmo[2]);
      end
    end
    tests_run++;
    if (pulses !== 0 || g_obs[2] !== 4'b0001) begin
      tests_failed++;
      $display("FAIL tie_release got %0d pulses, regrant g=%b want 0 pulses, g=0001", pulses, g_obs[2]);
    end
  endtask

  task automatic test_random();
    reset_all();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++)
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 5) == 0) req[d][i] = ~req[d][i];
      tick();
      for (int d = 0; d < 3; d++) begin
        tests_run++;
        if (g_obs[d] !== exp_grant(d) || i_obs[d] !== exp_index(d) || v_obs[d] !== (m_owner[d] >= 0) || t_obs[d] !== m_tmo[d] || !$onehot0(g_obs[d])) begin
          tests_failed++;
          $display("FAIL random d=%0d cyc=%0d got g=%b i=%0d v=%b t=%b want g=%b i=%0d v=%b t=%b", d, c, g_obs[d], i_obs[d], v_obs[d], t_obs[d], exp_grant(d), exp_index(d), (m_owner[d] >= 0), m_tmo[d]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    reset_all();
    req[0] = 4'b0010; tick(); tick();
    req[0] = 4'b0000; tick();
    req[0] = 4'b1000; tick();
    tests_run++;
    if (g_obs[0] !== 4'b1000 || g_obs[0] !== exp_grant(0)) begin
      tests_failed++;
      $display("FAIL midrst_setup got g=%b want 1000", g_obs[0]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (g_obs[0] !== 4'b0000 || v_obs[0] !== 1'b0 || i_obs[0] !== 3'd0) begin
      tests_failed++;
      $display("FAIL midrst_async got g=%b v=%b i=%0d want g=0000 v=0 i=0", g_obs[0], v_obs[0], i_obs[0]);
    end
    rst_n = 1'b1;
    req[0] = 4'b1111;
    tick();
    tests_run++;
    if (g_obs[0] !== 4'b0001 || g_obs[0] !== exp_grant(0)) begin
      tests_failed++;
      $display("FAIL midrst_ptr got g=%b want 0001", g_obs[0]);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    model_reset();
    for (int d = 0; d < 3; d++) req[d] = '0;
    bus0.request = '0;
    bus8.request = '0;
    bus4.request = '0;
    test_reset();
    test_single();
    test_fairness();
    test_watchdog();
    test_watchdog_tie();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
